// File: rtl/tdm_demux_if.sv
// Stream and frame-output bundle between a TDM source and the demultiplexer.
// The source side uses master; the demultiplexer uses slave.
interface tdm_demux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  logic [W-1:0]      d_in;
  logic              d_valid;
  logic              sync;
  logic [N_CH*W-1:0] ch_data;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  modport master (
    output d_in, d_valid, sync,
    input  ch_data, frame_done, locked, sync_err
  );

  modport slave (
    input  d_in, d_valid, sync,
    output ch_data, frame_done, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: stages one sample per valid beat into its channel slot.
// It publishes a whole frame on ch_data only when the last slot arrives.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic       clock,
  input  logic       reset_b,
  tdm_demux_if.slave bus
);
  localparam int CW = $clog2(N_CH);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [CW-1:0]     wr_idx;
  logic              stage_we;
  logic              publish;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [N_CH*W-1:0] stage_q;
  logic [N_CH*W-1:0] ch_data_q;
  logic [N_CH*W-1:0] frame_nxt;

  // The last sample bypasses staging so the frame publishes on the edge that samples it.
  always_comb begin
    frame_nxt = stage_q;
    frame_nxt[(N_CH-1)*W +: W] = bus.d_in;
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wr_idx   = '0;
    stage_we = 1'b0;
    publish  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (bus.d_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            stage_we = 1'b1;
            slot_d   = CW'(1);
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.sync) begin
            // Early sync abandons the partial frame and restarts at slot 0.
            err_d    = (slot_q != '0);
            stage_we = 1'b1;
            slot_d   = CW'(1);
          end else if (slot_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            wr_idx   = slot_q;
            stage_we = 1'b1;
            if (slot_q == CW'(N_CH-1)) begin
              slot_d  = '0;
              publish = 1'b1;
              done_d  = 1'b1;
            end else begin
              slot_d = slot_q + CW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= HUNT;
      slot_q    <= '0;
      stage_q   <= '0;
      ch_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (stage_we)
        stage_q[int'(wr_idx)*W +: W] <= bus.d_in;
      if (publish)
        ch_data_q <= frame_nxt;
    end
  end

  assign bus.ch_data    = ch_data_q;
  assign bus.frame_done = done_q;
  assign bus.sync_err   = err_q;
  assign bus.locked     = (state_q == LOCKED);
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: framing, gaps, hunt, early/missing sync and async reset.
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W    = 8;

  logic clock;
  logic reset_b;
  int   checks;
  int   failures;

  tdm_demux_if #(.N_CH(N_CH), .W(W)) bus ();

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one beat from a falling edge; return 1ns after the rising edge that samples it.
  task automatic beat(input logic [W-1:0] d, input logic s);
    @(negedge clock);
    bus.d_in    = d;
    bus.d_valid = 1'b1;
    bus.sync    = s;
    @(posedge clock);
    #1;
    bus.d_valid = 1'b0;
    bus.sync    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic async_reset_pulse();
    @(negedge clock);
    #2 reset_b = 1'b0;
    #1;
    chk("rst_ch_data", 64'(bus.ch_data), 64'h0);
    chk("rst_locked", 64'(bus.locked), 64'h0);
    chk("rst_done", 64'(bus.frame_done), 64'h0);
    chk("rst_err", 64'(bus.sync_err), 64'h0);
    reset_b = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_b     = 1'b1;
    bus.d_in    = '0;
    bus.d_valid = 1'b0;
    bus.sync    = 1'b0;

    // Async reset with no clock edge in between
    #2 reset_b = 1'b0;
    #1;
    chk("init_ch_data", 64'(bus.ch_data), 64'h0);
    chk("init_locked", 64'(bus.locked), 64'h0);
    chk("init_done", 64'(bus.frame_done), 64'h0);
    chk("init_err", 64'(bus.sync_err), 64'h0);
    @(negedge clock);
    reset_b = 1'b1;

    // Normal back-to-back frames
    beat(8'h11, 1'b1);
    chk("n1_locked", 64'(bus.locked), 64'h1);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    chk("n1_no_done_early", 64'(bus.frame_done), 64'h0);
    chk("n1_hold", 64'(bus.ch_data), 64'h0);
    beat(8'h44, 1'b0);
    chk("n1_ch_data", 64'(bus.ch_data), 64'h44332211);
    chk("n1_done", 64'(bus.frame_done), 64'h1);
    chk("n1_err", 64'(bus.sync_err), 64'h0);
    idle(1);
    chk("n1_done_pulse", 64'(bus.frame_done), 64'h0);
    beat(8'hA0, 1'b1);
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b0);
    beat(8'hA3, 1'b0);
    chk("n2_ch_data", 64'(bus.ch_data), 64'hA3A2A1A0);
    chk("n2_done", 64'(bus.frame_done), 64'h1);

    // Gapped valid, including a sync asserted without valid
    beat(8'h11, 1'b1);
    idle(2);
    beat(8'h22, 1'b0);
    @(negedge clock);
    bus.sync = 1'b1;
    @(posedge clock);
    #1;
    bus.sync = 1'b0;
    chk("g_sync_novalid_err", 64'(bus.sync_err), 64'h0);
    idle(1);
    beat(8'h33, 1'b0);
    chk("g_hold_old", 64'(bus.ch_data), 64'hA3A2A1A0);
    chk("g_no_done", 64'(bus.frame_done), 64'h0);
    idle(2);
    beat(8'h44, 1'b0);
    chk("g_ch_data", 64'(bus.ch_data), 64'h44332211);
    chk("g_done", 64'(bus.frame_done), 64'h1);
    chk("g_err", 64'(bus.sync_err), 64'h0);

    // HUNT discard after reset
    async_reset_pulse();
    beat(8'h55, 1'b0);
    chk("h_locked0", 64'(bus.locked), 64'h0);
    chk("h_err0", 64'(bus.sync_err), 64'h0);
    beat(8'h66, 1'b0);
    chk("h_locked1", 64'(bus.locked), 64'h0);
    chk("h_err1", 64'(bus.sync_err), 64'h0);
    beat(8'h01, 1'b1);
    chk("h_lock_rise", 64'(bus.locked), 64'h1);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    chk("h_err3", 64'(bus.sync_err), 64'h0);
    beat(8'h04, 1'b0);
    chk("h_ch_data", 64'(bus.ch_data), 64'h04030201);
    chk("h_done", 64'(bus.frame_done), 64'h1);
    chk("h_err4", 64'(bus.sync_err), 64'h0);

    // Early sync aborts the partial frame
    beat(8'h11, 1'b1);
    beat(8'h22, 1'b0);
    beat(8'h99, 1'b1);
    chk("e_err", 64'(bus.sync_err), 64'h1);
    chk("e_no_done", 64'(bus.frame_done), 64'h0);
    chk("e_hold", 64'(bus.ch_data), 64'h04030201);
    chk("e_locked", 64'(bus.locked), 64'h1);
    beat(8'h98, 1'b0);
    chk("e_err_pulse", 64'(bus.sync_err), 64'h0);
    beat(8'h97, 1'b0);
    chk("e_hold2", 64'(bus.ch_data), 64'h04030201);
    beat(8'h96, 1'b0);
    chk("e_ch_data", 64'(bus.ch_data), 64'h96979899);
    chk("e_done", 64'(bus.frame_done), 64'h1);
    chk("e_err_final", 64'(bus.sync_err), 64'h0);

    // Missing sync drops to HUNT
    beat(8'h77, 1'b0);
    chk("m_err", 64'(bus.sync_err), 64'h1);
    chk("m_locked", 64'(bus.locked), 64'h0);
    chk("m_ch_data", 64'(bus.ch_data), 64'h96979899);
    chk("m_done", 64'(bus.frame_done), 64'h0);
    idle(1);
    chk("m_err_pulse", 64'(bus.sync_err), 64'h0);

    // Reset mid-frame, then a clean frame
    beat(8'h10, 1'b1);
    beat(8'h20, 1'b0);
    async_reset_pulse();
    beat(8'hC1, 1'b1);
    beat(8'hC2, 1'b0);
    beat(8'hC3, 1'b0);
    chk("r_hold_zero", 64'(bus.ch_data), 64'h0);
    beat(8'hC4, 1'b0);
    chk("r_ch_data", 64'(bus.ch_data), 64'hC4C3C2C1);
    chk("r_done", 64'(bus.frame_done), 64'h1);
    chk("r_locked", 64'(bus.locked), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
